oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
Owns the single memory bus between the CPU master and the memory/MMU slave.
Implements the OAM DMA register (FF46): a CPU write starts a 160-byte copy from {src,00}..{src,9F} to FE00..FE9F, one byte per M-cycle.
While the copy is active, the DMA engine is granted the bus on T0/T1 of each M-cycle. The CPU is restricted to HRAM and FF46, on T2/T3 only.

Parameters:
DMA_REG, 16'hFF46, CPU-visible DMA source register address
OAM_BASE, 16'hFE00, copy destination base
DMA_LEN, 160, bytes per transfer
START_DELAY, 1, M-cycles between the FF46 write and the first copy read

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
t_phase  in  2  CPU T-state, increments every clk; an M-cycle boundary is 3->0
cpu_addr  in  16  CPU address
cpu_we  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data returned to CPU
mem_addr  out  16  address to memory
mem_we  out  1  memory write enable
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data; synchronous read, valid the clk after mem_addr is presented
dma_active  out  1  high in DMA_DELAY and DMA_ACTIVE
dma_done  out  1  one-clk pulse after the last byte is written

Behaviour:
- Reset:
  - state=DMA_IDLE, idx=0, dma_src=8'hFF, delay_cnt=0.
  - dma_active=0, dma_done=0; mem_we forced 0 while rst.
- FF46 access, any state:
  - CPU write to DMA_REG latches dma_src=cpu_wdata and is NOT forwarded to memory.
  - CPU read of DMA_REG returns dma_src.
- Source mapping: if dma_src>=8'hE0, the effective source high byte is dma_src-8'h20.
- Trigger: an FF46 write in any state moves to DMA_DELAY next clk, with delay_cnt=START_DELAY and idx=0.
  - An FF46 write during DMA_ACTIVE restarts the copy; the restart wins over a same-clk final write.
- DMA_DELAY:
  - CPU has full passthrough.
  - delay_cnt decrements at each M-boundary (t_phase==3).
  - At 0, move to DMA_ACTIVE, aligned so the first copy read occurs at the next t_phase==0.
- DMA_ACTIVE, per M-cycle:
  - T0: mem_addr={eff_src,idx[7:0]}, mem_we=0.
  - T1: mem_addr=OAM_BASE+idx, mem_we=1, mem_wdata=mem_rdata. idx increments at end of T1.
  - T2/T3: the CPU is granted only if cpu_addr is in FF80..FFFE or equals DMA_REG. Otherwise mem_we=0, CPU writes are dropped, and cpu_rdata=8'hFF.
  - On T0/T1, any CPU read returns 8'hFF.
  - After the T1 write with idx==DMA_LEN-1: state=DMA_IDLE next clk, dma_done=1 for exactly that clk.
- Total copy length: DMA_LEN M-cycles plus the delay.
- DMA_IDLE: combinational passthrough mem_*=cpu_* and cpu_rdata=mem_rdata, except for DMA_REG.
- idx is 8-bit; it never exceeds DMA_LEN-1, and there is no wrap.
- Reset mid-transfer aborts immediately. No further memory writes occur, and dma_done does not pulse.

Decomposition:
- cpu_defs package gains:
  - dma_state_t {DMA_IDLE, DMA_DELAY, DMA_ACTIVE}
  - constants REG_DMA_ADDR, OAM_BASE_ADDR, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE
- Sub-module dma_engine_m holds the FSM, idx, delay_cnt and dma_src, and emits the DMA address, we and grant.
- The top level holds the bus mux and the CPU permission check.

Test Plan:
1. IDLE passthrough: CPU write C000<=5A, then read C000 -> mem sees the write; cpu_rdata=5A; dma_active=0.
2. Full copy:
   - Stimulus: preload C000..C09F with i^8'h3C; CPU writes FF46<=C0.
   - Required: dma_active rises next clk; FE00..FE9F equal the pattern after 1+160 M-cycles; dma_done pulses once; dma_active drops.
3. CPU restriction during DMA:
   - Stimulus: CPU reads C010 and writes D000<=11 on T2; writes FF90<=77 on T3.
   - Required: the read returns FF; D000 is unchanged; FF90 reads back 77; the FF46 read returns C0.
4. Restart:
   - Stimulus: FF46<=C0, then FF46<=D0 at byte 50.
   - Required: the copy restarts at idx 0 from D000; FE00..FE9F end with D0xx data; a single dma_done pulse.
5. Echo source: FF46<=E1 -> reads come from C100..C19F.
6. Reset mid-copy: assert rst at byte 80 -> mem_we=0 from that clk; dma_src=FF; no dma_done; FE50.. retain their old values.

Source files
------------

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and bus constants for the OAM DMA arbiter slice.
// The echo-RAM fold-down of the DMA source page lives here so all users agree on it.
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_DELAY,
    DMA_ACTIVE
  } dma_state_t;

  localparam logic [15:0] REG_DMA_ADDR  = 16'hFF46;
  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam logic [15:0] HRAM_LO       = 16'hFF80;
  localparam logic [15:0] HRAM_HI       = 16'hFFFE;

  // Pages E0..FF mirror C0..DF, so the copy reads from the mirrored page.
  function automatic logic [7:0] eff_src_hi(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus of the OAM DMA arbiter.
// The arbiter uses the slave view; the bus owner (CPU and memory model) uses master.
interface oam_dma_arbiter_if;
  logic [1:0]  t_phase;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic        dma_done;

  modport slave (
    input  t_phase, cpu_addr, cpu_we, cpu_wdata, mem_rdata,
    output cpu_rdata, mem_addr, mem_we, mem_wdata, dma_active, dma_done
  );

  modport master (
    output t_phase, cpu_addr, cpu_we, cpu_wdata, mem_rdata,
    input  cpu_rdata, mem_addr, mem_we, mem_wdata, dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma_arbiter_dma_engine.sv
// OAM DMA engine: FF46 source register, start delay, and the per-M-cycle
// read (T0) / write (T1) sequencer that copies DMA_LEN bytes into OAM.
module dma_engine_m
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] OAM_BASE    = OAM_BASE_ADDR,
  parameter int unsigned DMA_LEN     = 160,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_phase,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  dma_src,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic        dma_grant,
  output logic        dma_restrict,
  output logic        dma_active,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [3:0] DELAY_INIT = 4'(START_DELAY);

  dma_state_t state, state_nx;
  logic [7:0] idx, idx_nx;
  logic [3:0] delay_cnt, delay_nx;
  logic       done_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DMA_IDLE;
      idx       <= 8'd0;
      delay_cnt <= 4'd0;
      dma_src   <= 8'hFF;
      dma_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      delay_cnt <= delay_nx;
      dma_done  <= done_nx;
      if (reg_wr) dma_src <= reg_wdata;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    delay_nx = delay_cnt;
    done_nx  = 1'b0;
    dma_addr = {eff_src_hi(dma_src), idx};
    dma_we   = 1'b0;
    case (state)
      DMA_IDLE: ;
      // Leaving on t_phase==3 makes the first source read land on the next T0.
      DMA_DELAY: begin
        if (t_phase == 2'd3) begin
          if (delay_cnt <= 4'd1) begin
            state_nx = DMA_ACTIVE;
            delay_nx = 4'd0;
          end else begin
            delay_nx = delay_cnt - 4'd1;
          end
        end
      end
      DMA_ACTIVE: begin
        if (t_phase == 2'd1) begin
          dma_addr = OAM_BASE + {8'h00, idx};
          dma_we   = 1'b1;
          if (idx == LAST_IDX) begin
            state_nx = DMA_IDLE;
            idx_nx   = 8'd0;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + 8'd1;
          end
        end
      end
      default: state_nx = DMA_IDLE;
    endcase
    // A register write restarts the copy and overrides a same-clk completion.
    if (reg_wr) begin
      state_nx = DMA_DELAY;
      delay_nx = DELAY_INIT;
      idx_nx   = 8'd0;
      done_nx  = 1'b0;
    end
  end

  assign dma_active   = (state != DMA_IDLE);
  assign dma_restrict = (state == DMA_ACTIVE);
  assign dma_grant    = (state == DMA_ACTIVE) && !t_phase[1];

endmodule

// File: rtl/oam_dma_arbiter.sv
// Single-bus arbiter between the CPU and memory with the OAM DMA engine.
// DMA owns T0/T1 while copying; the CPU keeps only HRAM and FF46 on T2/T3.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_REG     = REG_DMA_ADDR,
  parameter logic [15:0] OAM_BASE    = OAM_BASE_ADDR,
  parameter int unsigned DMA_LEN     = 160,
  parameter int unsigned START_DELAY = 1
) (
  input logic              clk,
  input logic              rst,
  oam_dma_arbiter_if.slave bus
);

  logic        is_reg;
  logic        cpu_ok;
  logic [7:0]  dma_src;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic        dma_grant;
  logic        dma_restrict;

  assign is_reg = (bus.cpu_addr == DMA_REG);
  assign cpu_ok = is_reg || ((bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI));

  dma_engine_m #(
    .OAM_BASE    (OAM_BASE),
    .DMA_LEN     (DMA_LEN),
    .START_DELAY (START_DELAY)
  ) u_engine (
    .clk          (clk),
    .rst          (rst),
    .t_phase      (bus.t_phase),
    .reg_wr       (bus.cpu_we && is_reg),
    .reg_wdata    (bus.cpu_wdata),
    .dma_src      (dma_src),
    .dma_addr     (dma_addr),
    .dma_we       (dma_we),
    .dma_grant    (dma_grant),
    .dma_restrict (dma_restrict),
    .dma_active   (bus.dma_active),
    .dma_done     (bus.dma_done)
  );

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_we    = bus.cpu_we && !is_reg;
    bus.mem_wdata = bus.cpu_wdata;
    bus.cpu_rdata = is_reg ? dma_src : bus.mem_rdata;
    if (dma_grant) begin
      // The T1 write forwards the byte fetched on T0 straight from the read port.
      bus.mem_addr  = dma_addr;
      bus.mem_we    = dma_we;
      bus.mem_wdata = bus.mem_rdata;
      bus.cpu_rdata = 8'hFF;
    end else if (dma_restrict && !cpu_ok) begin
      bus.mem_we    = 1'b0;
      bus.cpu_rdata = 8'hFF;
    end
    if (rst) bus.mem_we = 1'b0;
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized scoreboard bench for oam_dma_arbiter with a behavioural memory
// and a byte-level reference model of the copy and CPU access rules.
module tb_oam_dma_arbiter;
  import oam_dma_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tp  = 2'd0;
  bit   [7:0] mem     [65536];
  bit   [7:0] ref_mem [65536];
  logic [23:0] dma_q[$];
  logic [23:0] cpu_q[$];
  logic [23:0] rd_q[$];
  logic [23:0] mon_e;
  logic        rd_strobe  = 1'b0;
  logic        model_busy = 1'b0;
  logic [7:0]  cur_src    = 8'h00;
  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  int exp_done = 0;

  oam_dma_arbiter_if bus();

  oam_dma_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tp <= tp + 2'd1;
  assign bus.t_phase = tp;

  // Synchronous-read memory: data for an address appears the clk after it is presented.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endfunction

  // Monitor: every memory write and every sampled read is matched against the model queues.
  always @(negedge clk) begin
    if (rst) begin
      chk("mem_we_in_rst", 32'(bus.mem_we), 32'd0);
    end else if (bus.mem_we) begin
      if (tp == 2'd1 && dma_q.size() > 0) begin
        mon_e = dma_q.pop_front();
        chk("dma_wr", 32'({bus.mem_addr, bus.mem_wdata}), 32'(mon_e));
      end else if (cpu_q.size() > 0) begin
        mon_e = cpu_q.pop_front();
        chk("cpu_wr", 32'({bus.mem_addr, bus.mem_wdata}), 32'(mon_e));
      end else begin
        n_chk++;
        $display("FAIL unexpected_wr: got write %h<=%h, required no write", bus.mem_addr, bus.mem_wdata);
      end
    end
    if (bus.dma_done) done_seen++;
    if (rd_strobe && rd_q.size() > 0) begin
      mon_e = rd_q.pop_front();
      chk($sformatf("rd_%h", mon_e[23:8]), 32'(bus.cpu_rdata), 32'(mon_e[7:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tp == p) break;
    end
  endtask

  function automatic bit is_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  // Model of CPU writes: FF46 never reaches memory; during a copy only HRAM does.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    if (a != 16'hFF46 && (!model_busy || is_hram(a))) begin
      cpu_q.push_back({a, d});
      ref_mem[a] = d;
    end
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    tick();
    bus.cpu_we    = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    bus.cpu_addr = a;
    bus.cpu_we   = 1'b0;
    tick();
    rd_q.push_back({a, exp});
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] v);
    logic [7:0] ib;
    cur_src = (v >= 8'hE0) ? (v - 8'h20) : v;
    dma_q.delete();
    for (int i = 0; i < 160; i++) begin
      ib = 8'(i);
      dma_q.push_back({16'hFE00 + 16'(i), ref_mem[{cur_src, ib}]});
    end
    model_busy = 1'b1;
    cpu_write(16'hFF46, v);
  endtask

  task automatic apply_copy(input logic [7:0] src, input int n);
    logic [7:0] ib;
    for (int i = 0; i < n; i++) begin
      ib = 8'(i);
      ref_mem[16'hFE00 + 16'(i)] = ref_mem[{src, ib}];
    end
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (dma_q.size() <= n) break;
      tick();
    end
    chk("dma_progress", 32'(dma_q.size()), 32'(n));
  endtask

  task automatic finish_copy();
    exp_done++;
    for (int i = 0; i < 800; i++) begin
      if (done_seen >= exp_done) break;
      tick();
    end
    chk("dma_active_after", 32'(bus.dma_active), 32'd0);
    repeat (8) tick();
    chk("done_count", 32'(done_seen), 32'(exp_done));
    chk("dma_q_left", 32'(dma_q.size()), 32'd0);
    apply_copy(cur_src, 160);
    model_busy = 1'b0;
  endtask

  task automatic chk_oam();
    for (int i = 0; i < 160; i++)
      chk($sformatf("oam_%0d", i), 32'(mem[16'hFE00 + 16'(i)]), 32'(ref_mem[16'hFE00 + 16'(i)]));
  endtask

  initial begin
    logic [15:0] ha;
    logic [7:0]  hd;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = 8'h00;
    repeat (3) tick();
    chk("rst_active", 32'(bus.dma_active), 32'd0);
    chk("rst_done", 32'(bus.dma_done), 32'd0);
    rst = 1'b0;
    tick();
    cpu_read(16'hFF46, 8'hFF);

    // Idle passthrough
    cpu_write(16'hC000, 8'h5A);
    cpu_read(16'hC000, 8'h5A);
    chk("idle_active", 32'(bus.dma_active), 32'd0);

    // Full copy of a known pattern
    for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'h3C);
    start_dma(8'hC0);
    chk("active_rise", 32'(bus.dma_active), 32'd1);
    finish_copy();
    chk_oam();

    // CPU restrictions while copying
    start_dma(8'hC0);
    wait_q(159);
    ha = 16'hFF80 + 16'($urandom_range(0, 126));
    if (ha == 16'hFF46) ha = 16'hFF90;
    hd = 8'($urandom);
    wait_phase(2'd2);
    cpu_write(16'hD000, 8'h11);
    cpu_write(ha, hd);
    wait_phase(2'd2);
    cpu_read(16'hC010, 8'hFF);
    wait_phase(2'd2);
    cpu_read(ha, ref_mem[ha]);
    wait_phase(2'd2);
    cpu_read(16'hFF46, 8'hC0);
    wait_phase(2'd0);
    cpu_read(ha, 8'hFF);
    finish_copy();
    chk("d000_kept", 32'(mem[16'hD000]), 32'(ref_mem[16'hD000]));

    // Restart mid-copy with a new source page
    for (int i = 0; i < 160; i++) cpu_write(16'hD000 + 16'(i), 8'($urandom));
    start_dma(8'hC0);
    wait_q(110);
    start_dma(8'hD0);
    finish_copy();
    chk_oam();

    // Echo-page source
    for (int i = 0; i < 160; i++) cpu_write(16'hC100 + 16'(i), 8'($urandom));
    start_dma(8'hE1);
    wait_q(100);
    wait_phase(2'd2);
    cpu_read(16'hFF46, 8'hE1);
    finish_copy();
    chk_oam();

    // Reset mid-copy, with a CPU HRAM write held across the reset
    start_dma(8'hC0);
    wait_q(80);
    rst           = 1'b1;
    bus.cpu_addr  = 16'hFF81;
    bus.cpu_wdata = 8'hAA;
    bus.cpu_we    = 1'b1;
    tick();
    tick();
    rst        = 1'b0;
    bus.cpu_we = 1'b0;
    dma_q.delete();
    model_busy = 1'b0;
    apply_copy(cur_src, 80);
    cpu_read(16'hFF46, 8'hFF);
    chk("rst_mid_active", 32'(bus.dma_active), 32'd0);
    repeat (300) tick();
    chk("rst_mid_no_done", 32'(done_seen), 32'(exp_done));
    chk_oam();
    chk("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
